// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IF/ID instruction/PC registers and LDM immediate capture.
// Define RESET_VECTOR_EN to fetch the 32-bit reset vector from imem words 0/1 before running.
module fetch_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_write,
   input  logic        clear_instruction,
   input  logic        jump_taken,
   input  logic [31:0] jump_target,
   input  logic        pc_choose_memory,
   input  logic [31:0] mem_pc,
   input  logic [15:0] imem_data,
   output logic [31:0] imem_addr,
   output logic [15:0] instruction,
   output logic [31:0] pc_out,
   output logic [15:0] immediate,
   output logic        fetch_valid
);

   localparam logic [15:0] NOP = 16'h4000;

   logic [31:0] pc;
   logic [31:0] run_pc;
   logic [15:0] run_instr;
   logic [31:0] run_pc_out;
   logic [15:0] run_imm;
   logic        redirect;

   // Next-state of the RUN datapath; redirect outranks stall, stall outranks clear.
   always_comb begin
      redirect   = pc_choose_memory | jump_taken;
      run_pc     = pc;
      run_instr  = instruction;
      run_pc_out = pc_out;
      run_imm    = immediate;
      if (pc_choose_memory)  run_pc = mem_pc;
      else if (jump_taken)   run_pc = jump_target;
      else if (pc_write)     run_pc = pc + 32'd1;
      if (redirect) begin
         run_instr  = NOP;
         run_pc_out = pc;
      end else if (pc_write) begin
         run_pc_out = pc;
         if (clear_instruction) begin
            run_instr = NOP;
            run_imm   = imem_data;
         end else begin
            run_instr = imem_data;
         end
      end
   end

`ifdef RESET_VECTOR_EN
   typedef enum logic [1:0] {LOAD_HI, LOAD_LO, RUN} state_t;

   state_t      state;
   logic [15:0] vec_hi;

   always_comb begin
      case (state)
         LOAD_HI: imem_addr = '0;
         LOAD_LO: imem_addr = 32'd1;
         default: imem_addr = pc;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= LOAD_HI;
         vec_hi      <= '0;
         pc          <= '0;
         instruction <= NOP;
         pc_out      <= '0;
         immediate   <= '0;
      end else begin
         case (state)
            LOAD_HI: begin
               vec_hi      <= imem_data;
               instruction <= NOP;
               state       <= LOAD_LO;
            end
            LOAD_LO: begin
               pc          <= {vec_hi, imem_data};
               instruction <= NOP;
               state       <= RUN;
            end
            default: begin
               pc          <= run_pc;
               instruction <= run_instr;
               pc_out      <= run_pc_out;
               immediate   <= run_imm;
            end
         endcase
      end
   end

   assign fetch_valid = (state == RUN);
`else
   assign imem_addr = pc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc          <= '0;
         instruction <= NOP;
         pc_out      <= '0;
         immediate   <= '0;
      end else begin
         pc          <= run_pc;
         instruction <= run_instr;
         pc_out      <= run_pc_out;
         immediate   <= run_imm;
      end
   end

   // Without a vector load the stage is always running.
   assign fetch_valid = 1'b1;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; works with or without RESET_VECTOR_EN.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_write;
   logic        clear_instruction;
   logic        jump_taken;
   logic [31:0] jump_target;
   logic        pc_choose_memory;
   logic [31:0] mem_pc;
   logic [15:0] imem_data;
   logic [31:0] imem_addr;
   logic [15:0] instruction;
   logic [31:0] pc_out;
   logic [15:0] immediate;
   logic        fetch_valid;

   int checks   = 0;
   int failures = 0;

   localparam logic [15:0] NOP = 16'h4000;

   fetch_stage dut (
      .clk               (clk),
      .reset             (reset),
      .pc_write          (pc_write),
      .clear_instruction (clear_instruction),
      .jump_taken        (jump_taken),
      .jump_target       (jump_target),
      .pc_choose_memory  (pc_choose_memory),
      .mem_pc            (mem_pc),
      .imem_data         (imem_data),
      .imem_addr         (imem_addr),
      .instruction       (instruction),
      .pc_out            (pc_out),
      .immediate         (immediate),
      .fetch_valid       (fetch_valid)
   );

   always #5 clk = ~clk;

   // Word 0/1 hold the reset vector 0x0000_0020; 0x31 holds the LDM immediate.
   function automatic logic [15:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 16'h0000;
         32'h1:   return 16'h0020;
         32'h31:  return 16'hBEEF;
         default: return {4'h1, a[11:0]};
      endcase
   endfunction

   always_comb imem_data = mem_word(imem_addr);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pc_write          = 1'b1;
      clear_instruction = 1'b0;
      jump_taken        = 1'b0;
      jump_target       = '0;
      pc_choose_memory  = 1'b0;
      mem_pc            = '0;
   endtask

   task automatic jump_to(input logic [31:0] t);
      jump_taken  = 1'b1;
      jump_target = t;
      step();
      jump_taken  = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0;
      #23;
      checks++; if (instruction !== NOP) begin failures++; $display("FAIL rst_instr got=%h exp=%h", instruction, NOP); end
      checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL rst_pc_out got=%h exp=0", pc_out); end
      checks++; if (immediate !== 16'h0) begin failures++; $display("FAIL rst_imm got=%h exp=0", immediate); end
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
`ifdef RESET_VECTOR_EN
      checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", fetch_valid); end
`else
      checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL rst_valid got=%b exp=1", fetch_valid); end
`endif
   endtask

   // Brings the PC to 0x20 with instruction=NOP in both builds.
   task automatic test_startup();
      step();
      #3 reset = 1'b1;
`ifdef RESET_VECTOR_EN
      step();
      checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL lo_valid got=%b exp=0", fetch_valid); end
      checks++; if (imem_addr !== 32'h1) begin failures++; $display("FAIL lo_addr got=%h exp=1", imem_addr); end
      checks++; if (instruction !== NOP) begin failures++; $display("FAIL lo_instr got=%h exp=%h", instruction, NOP); end
      step();
      checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL vec_valid got=%b exp=1", fetch_valid); end
      checks++; if (imem_addr !== 32'h20) begin failures++; $display("FAIL vec_addr got=%h exp=20", imem_addr); end
      checks++; if (instruction !== NOP) begin failures++; $display("FAIL vec_instr got=%h exp=%h", instruction, NOP); end
      checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL vec_pc_out got=%h exp=0", pc_out); end
`else
      step();
      checks++; if (imem_addr !== 32'h1) begin failures++; $display("FAIL run0_addr got=%h exp=1", imem_addr); end
      checks++; if (instruction !== 16'h0000) begin failures++; $display("FAIL run0_instr got=%h exp=0000", instruction); end
      checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL run0_pc_out got=%h exp=0", pc_out); end
      jump_to(32'h20);
      checks++; if (imem_addr !== 32'h20) begin failures++; $display("FAIL jmp20_addr got=%h exp=20", imem_addr); end
      checks++; if (instruction !== NOP) begin failures++; $display("FAIL jmp20_instr got=%h exp=%h", instruction, NOP); end
      checks++; if (pc_out !== 32'h1) begin failures++; $display("FAIL jmp20_pc_out got=%h exp=1", pc_out); end
`endif
   endtask

   task automatic test_stall();
      logic [31:0] held_pc_out;
`ifdef RESET_VECTOR_EN
      held_pc_out = 32'h0;
`else
      held_pc_out = 32'h1;
`endif
      pc_write = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (imem_addr !== 32'h20) begin failures++; $display("FAIL stall_addr[%0d] got=%h exp=20", i, imem_addr); end
         checks++; if (instruction !== NOP) begin failures++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, instruction, NOP); end
         checks++; if (pc_out !== held_pc_out) begin failures++; $display("FAIL stall_pc_out[%0d] got=%h exp=%h", i, pc_out, held_pc_out); end
      end
      pc_write = 1'b1;
      step();
      checks++; if (imem_addr !== 32'h21) begin failures++; $display("FAIL unstall_addr got=%h exp=21", imem_addr); end
      checks++; if (instruction !== 16'h1020) begin failures++; $display("FAIL unstall_instr got=%h exp=1020", instruction); end
      checks++; if (pc_out !== 32'h20) begin failures++; $display("FAIL unstall_pc_out got=%h exp=20", pc_out); end
   endtask

   task automatic test_ldm();
      jump_to(32'h30);
      checks++; if (pc_out !== 32'h21) begin failures++; $display("FAIL j30_pc_out got=%h exp=21", pc_out); end
      step();
      checks++; if (instruction !== 16'h1030) begin failures++; $display("FAIL ldm_instr got=%h exp=1030", instruction); end
      clear_instruction = 1'b1;
      step();
      clear_instruction = 1'b0;
      checks++; if (immediate !== 16'hBEEF) begin failures++; $display("FAIL ldm_imm got=%h exp=beef", immediate); end
      checks++; if (instruction !== NOP) begin failures++; $display("FAIL ldm_nop got=%h exp=%h", instruction, NOP); end
      checks++; if (pc_out !== 32'h31) begin failures++; $display("FAIL ldm_pc_out got=%h exp=31", pc_out); end
      checks++; if (imem_addr !== 32'h32) begin failures++; $display("FAIL ldm_addr got=%h exp=32", imem_addr); end
      step();
      checks++; if (instruction !== 16'h1032) begin failures++; $display("FAIL post_ldm_instr got=%h exp=1032", instruction); end
      checks++; if (immediate !== 16'hBEEF) begin failures++; $display("FAIL post_ldm_imm got=%h exp=beef", immediate); end
      // Clear during a stall must not capture or advance.
      clear_instruction = 1'b1;
      pc_write          = 1'b0;
      step();
      clear_instruction = 1'b0;
      pc_write          = 1'b1;
      checks++; if (imem_addr !== 32'h33) begin failures++; $display("FAIL clrstall_addr got=%h exp=33", imem_addr); end
      checks++; if (instruction !== 16'h1032) begin failures++; $display("FAIL clrstall_instr got=%h exp=1032", instruction); end
      checks++; if (immediate !== 16'hBEEF) begin failures++; $display("FAIL clrstall_imm got=%h exp=beef", immediate); end
   endtask

   task automatic test_redirect();
      jump_taken       = 1'b1;
      pc_choose_memory = 1'b1;
      pc_write         = 1'b0;
      jump_target      = 32'h100;
      mem_pc           = 32'h200;
      step();
      idle_inputs();
      checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL prio_addr got=%h exp=200", imem_addr); end
      checks++; if (instruction !== NOP) begin failures++; $display("FAIL prio_instr got=%h exp=%h", instruction, NOP); end
      checks++; if (pc_out !== 32'h33) begin failures++; $display("FAIL prio_pc_out got=%h exp=33", pc_out); end
      step();
      checks++; if (instruction !== 16'h1200) begin failures++; $display("FAIL prio_tgt_instr got=%h exp=1200", instruction); end
      checks++; if (pc_out !== 32'h200) begin failures++; $display("FAIL prio_tgt_pc_out got=%h exp=200", pc_out); end
      // Jump with clear set: redirect wins, immediate untouched.
      clear_instruction = 1'b1;
      jump_to(32'h100);
      clear_instruction = 1'b0;
      checks++; if (instruction !== NOP) begin failures++; $display("FAIL jclr_instr got=%h exp=%h", instruction, NOP); end
      checks++; if (immediate !== 16'hBEEF) begin failures++; $display("FAIL jclr_imm got=%h exp=beef", immediate); end
      step();
      checks++; if (instruction !== 16'h1100) begin failures++; $display("FAIL jclr_tgt got=%h exp=1100", instruction); end
   endtask

   task automatic test_wrap();
      jump_to(32'hFFFF_FFFF);
      checks++; if (imem_addr !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_pre got=%h exp=ffffffff", imem_addr); end
      step();
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
      checks++; if (instruction !== 16'h1FFF) begin failures++; $display("FAIL wrap_instr got=%h exp=1fff", instruction); end
      checks++; if (pc_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_pc_out got=%h exp=ffffffff", pc_out); end
   endtask

   task automatic test_reset_midrun();
      jump_to(32'h55);
      checks++; if (imem_addr !== 32'h55) begin failures++; $display("FAIL mid_pre got=%h exp=55", imem_addr); end
      #3 reset = 1'b0;
      #1;
      checks++; if (instruction !== NOP) begin failures++; $display("FAIL mid_instr got=%h exp=%h", instruction, NOP); end
      checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL mid_pc_out got=%h exp=0", pc_out); end
      checks++; if (immediate !== 16'h0) begin failures++; $display("FAIL mid_imm got=%h exp=0", immediate); end
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL mid_addr got=%h exp=0", imem_addr); end
      step();
      #3 reset = 1'b1;
`ifdef RESET_VECTOR_EN
      checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", fetch_valid); end
      step();
      // Abort in LOAD_LO, then reload the full vector.
      #3 reset = 1'b0;
      #1;
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL abort_lo_addr got=%h exp=0", imem_addr); end
      checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL abort_lo_valid got=%b exp=0", fetch_valid); end
      step();
      #3 reset = 1'b1;
      step();
      step();
      checks++; if (imem_addr !== 32'h20) begin failures++; $display("FAIL reload_addr got=%h exp=20", imem_addr); end
      checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL reload_valid got=%b exp=1", fetch_valid); end
`else
      checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL mid_valid got=%b exp=1", fetch_valid); end
      step();
      checks++; if (imem_addr !== 32'h1) begin failures++; $display("FAIL restart_addr got=%h exp=1", imem_addr); end
      checks++; if (instruction !== 16'h0000) begin failures++; $display("FAIL restart_instr got=%h exp=0000", instruction); end
`endif
   endtask

   initial begin
      test_reset();
      test_startup();
      test_stall();
      test_ldm();
      test_redirect();
      test_wrap();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
